// File: rtl/burst_ctrl.sv
// burst_ctrl: burst master controller that opens the burst_enable window, waits for the
// master grant and counts qualified beats. Stall abort is enabled by BURST_CTRL_STALL_ABORT_EN.
module burst_ctrl #(
   parameter int unsigned BURST_LEN     = 6,
   parameter int unsigned GRANT_TIMEOUT = 4,
   parameter int unsigned STALL_MAX     = 3,
   localparam int unsigned CNT_W = $clog2(BURST_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             burst_req_i,
   input  logic             master_busy_i,
   input  logic             slave_busy_i,
   output logic             burst_enable_o,
   output logic             beat_valid_o,
   output logic [CNT_W-1:0] beat_cnt_o,
   output logic             burst_done_o,
   output logic             burst_err_o
);

   localparam int unsigned WAIT_W = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_M,
      S_XFER,
      S_DONE,
      S_ERR
   } state_t;

   state_t             state_q;
   logic [WAIT_W-1:0]  wait_cnt_q;
   logic [CNT_W-1:0]   beat_cnt_q;
   logic               burst_enable_q;
   logic               beat_valid_q;
   logic               burst_done_q;
   logic               burst_err_q;
   logic               beat_c;

   assign beat_c = !master_busy_i && !slave_busy_i;

`ifdef BURST_CTRL_STALL_ABORT_EN
   localparam int unsigned STALL_W = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
   logic [STALL_W-1:0] stall_cnt_q;
`else
   // STALL_MAX only shapes the stall abort path; keep the parameter referenced.
   if (STALL_MAX == 0) begin : g_no_stall_abort
   end
`endif

   // Window/pulse outputs follow the state held during the previous cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         wait_cnt_q     <= '0;
         beat_cnt_q     <= '0;
         burst_enable_q <= 1'b0;
         beat_valid_q   <= 1'b0;
         burst_done_q   <= 1'b0;
         burst_err_q    <= 1'b0;
`ifdef BURST_CTRL_STALL_ABORT_EN
         stall_cnt_q    <= '0;
`endif
      end else begin
         burst_enable_q <= (state_q == S_WAIT_M) || (state_q == S_XFER);
         burst_done_q   <= (state_q == S_DONE);
         burst_err_q    <= (state_q == S_ERR);
         beat_valid_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (burst_req_i) begin
                  state_q    <= S_WAIT_M;
                  wait_cnt_q <= '0;
                  beat_cnt_q <= '0;
`ifdef BURST_CTRL_STALL_ABORT_EN
                  stall_cnt_q <= '0;
`endif
               end
            end
            S_WAIT_M: begin
               if (!master_busy_i) begin
                  state_q <= S_XFER;
               end else if (wait_cnt_q == WAIT_W'(GRANT_TIMEOUT)) begin
                  state_q <= S_ERR;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
               end
            end
            S_XFER: begin
               if (beat_c) begin
                  beat_valid_q <= 1'b1;
                  beat_cnt_q   <= beat_cnt_q + CNT_W'(1);
`ifdef BURST_CTRL_STALL_ABORT_EN
                  stall_cnt_q  <= '0;
`endif
                  if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) begin
                     state_q <= S_DONE;
                  end
               end else begin
`ifdef BURST_CTRL_STALL_ABORT_EN
                  if (stall_cnt_q == STALL_W'(STALL_MAX)) begin
                     state_q <= S_ERR;
                  end else begin
                     stall_cnt_q <= stall_cnt_q + STALL_W'(1);
                  end
`endif
               end
            end
            S_DONE:  state_q <= S_IDLE;
            S_ERR:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign burst_enable_o = burst_enable_q;
   assign beat_valid_o   = beat_valid_q;
   assign beat_cnt_o     = beat_cnt_q;
   assign burst_done_o   = burst_done_q;
   assign burst_err_o    = burst_err_q;

endmodule

// File: tb/tb_burst_ctrl.sv
// tb_burst_ctrl: directed and random bursts checked against a per-burst expected trace
// derived from grant delay and per-beat stall lengths.
module tb_burst_ctrl;

   localparam int unsigned BL = 6;
   localparam int unsigned GT = 4;
   localparam int unsigned SM = 3;
   localparam int unsigned CW = $clog2(BL + 1);
   localparam int MAXN = 256;
`ifdef BURST_CTRL_STALL_ABORT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic req, mb, sb;
   logic en, bv, done, err;
   logic [CW-1:0] bc;

   burst_ctrl #(.BURST_LEN(BL), .GRANT_TIMEOUT(GT), .STALL_MAX(SM)) dut (
      .clk           (clk),
      .rst           (rst),
      .burst_req_i   (req),
      .master_busy_i (mb),
      .slave_busy_i  (sb),
      .burst_enable_o(en),
      .beat_valid_o  (bv),
      .beat_cnt_o    (bc),
      .burst_done_o  (done),
      .burst_err_o   (err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Expected trace: inputs at edge i and outputs observed just after edge i.
   logic t_req [MAXN];
   logic t_mb  [MAXN];
   logic t_sb  [MAXN];
   logic x_en  [MAXN];
   logic x_bv  [MAXN];
   logic x_dn  [MAXN];
   logic x_er  [MAXN];
   int   x_bc  [MAXN];
   int   n;
   int   held_bc = 0;
   int   stalls [BL];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic put(input logic r, input logic m, input logic s,
                      input logic e, input logic v, input logic d, input logic x, input int c);
      t_req[n] = r; t_mb[n] = m; t_sb[n] = s;
      x_en[n] = e; x_bv[n] = v; x_dn[n] = d; x_er[n] = x; x_bc[n] = c;
      n++;
   endtask

   task automatic clear_stalls();
      for (int k = 0; k < int'(BL); k++) stalls[k] = 0;
   endtask

   // g = cycles master_busy stays high in WAIT_M; stalls[k] = stall cycles before beat k+1.
   task automatic build(input int g);
      bit aborted;
      int cnt;
      int v;
      aborted = 1'b0;
      cnt = 0;
      n = 0;
      put(1'b1, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 0);
      for (int w = 1; w <= g && w <= int'(GT) + 1; w++)
         put(1'b0, 1'b1, rb(), 1'b1, 1'b0, 1'b0, 1'b0, 0);
      if (g > int'(GT)) begin
         aborted = 1'b1;
      end else begin
         put(1'b0, 1'b0, rb(), 1'b1, 1'b0, 1'b0, 1'b0, 0);
         for (int k = 0; k < int'(BL) && !aborted; k++) begin
            int ns;
            ns = stalls[k];
            if (ABORT && ns > int'(SM)) begin
               ns = int'(SM) + 1;
               aborted = 1'b1;
            end
            for (int s = 0; s < ns; s++) begin
               v = int'($urandom_range(1, 3));
               put(1'b0, v[1], v[0], 1'b1, 1'b0, 1'b0, 1'b0, cnt);
            end
            if (!aborted) begin
               cnt++;
               put(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, cnt);
            end
         end
      end
      put(1'b0, rb(), rb(), 1'b0, 1'b0, !aborted, aborted, cnt);
      // Requests while the burst is in flight must be ignored.
      for (int i = 1; i < n; i++)
         if ($urandom_range(0, 3) == 0) t_req[i] = 1'b1;
   endtask

   task automatic run(input int upto);
      int   rises;
      logic prev;
      rises = 0;
      prev  = en;
      for (int i = 0; i < upto; i++) begin
         @(negedge clk);
         req = t_req[i]; mb = t_mb[i]; sb = t_sb[i];
         @(posedge clk);
         #1;
         chk("burst_enable", en, x_en[i]);
         chk("beat_valid", bv, x_bv[i]);
         chk("beat_cnt", bc, x_bc[i]);
         chk("burst_done", done, x_dn[i]);
         chk("burst_err", err, x_er[i]);
         if (!prev && en) rises++;
         prev = en;
      end
      held_bc = x_bc[upto-1];
      if (upto == n) chk("enable_rises", rises, 1);
   endtask

   task automatic idle(input int c);
      for (int i = 0; i < c; i++) begin
         @(negedge clk);
         req = 1'b0; mb = rb(); sb = rb();
         @(posedge clk);
         #1;
         chk("idle_enable", en, 0);
         chk("idle_valid", bv, 0);
         chk("idle_done", done, 0);
         chk("idle_err", err, 0);
         chk("idle_cnt", bc, held_bc);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_enable"}, en, 0);
      chk({tag, "_valid"}, bv, 0);
      chk({tag, "_cnt"}, bc, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; mb = 1'b0; sb = 1'b0;
      #2;
      check_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // nominal: grant two cycles after enable rises, no stalls
      clear_stalls(); build(2); run(n); idle(1);
      // grant timeout
      clear_stalls(); build(int'(GT) + 1); run(n); idle(1);
      // grant on the last allowed WAIT_M cycle
      clear_stalls(); build(int'(GT)); run(n); idle(1);
      // stall of STALL_MAX cycles after beat 2
      clear_stalls(); stalls[2] = int'(SM); build(0); run(n); idle(1);
      // stall one beyond STALL_MAX after beat 2
      clear_stalls(); stalls[2] = int'(SM) + 1; build(1); run(n); idle(1);

      // requests in XFER and DONE ignored, then back-to-back burst
      clear_stalls(); build(1);
      t_req[4] = 1'b1; t_req[n-1] = 1'b1;
      run(n);
      clear_stalls(); build(0); run(n); idle(1);

      // reset in XFER after the third beat (edges: req, 2 wait, grant, beats 1..3)
      clear_stalls(); build(2);
      run(7);
      chk("pre_reset_cnt", bc, 3);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_zero("async_reset");
      @(posedge clk);
      #1;
      check_zero("held_reset");
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      held_bc = 0;
      idle(3);

      for (int b = 0; b < 40; b++) begin
         clear_stalls();
         for (int k = 0; k < int'(BL); k++)
            if ($urandom_range(0, 3) == 0) stalls[k] = int'($urandom_range(1, SM + 1));
         build(int'($urandom_range(0, GT + 1)));
         run(n);
         idle(int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
